cache_arbiter: RTL and testbench

Shares the single physical-memory line port between the L1 instruction cache and the L1 data cache. Each cache presents a line-granular request (256-bit fill or write-back). The arbiter grants one requester at a time, latches its request, drives the downstream memory port from those registers, and returns the response only to the granted cache. It sits between the two cache controllers and the memory/burst adapter.

---
 rtl/cache_types_pkg.sv | 18 +
 rtl/arb_grant_sel.sv | 20 ++
 rtl/cache_arbiter.sv | 110 +++++++++++
 tb/tb_cache_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_pkg.sv
// Types and constants shared by the I/D cache-to-memory arbiter.
package cache_types_pkg;

  localparam int LINE_WIDTH = 256;
  localparam int OFS        = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_e;

endpackage

// File: rtl/arb_grant_sel.sv
// Picks the winner between the I- and D-cache pending bits.
// A tie goes to whichever requester was not granted last.
module arb_grant_sel
  import cache_types_pkg::*;
(
  input  logic       i_pend,
  input  logic       d_pend,
  input  requester_e last_grant,
  output requester_e winner
);

  always_comb begin
    winner = REQ_I;
    if (i_pend && d_pend)
      winner = (last_grant == REQ_I) ? REQ_D : REQ_I;
    else if (d_pend)
      winner = REQ_D;
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one line-granular memory port between the L1 I-cache and D-cache.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the D-cache always wins a tie.
module cache_arbiter
  import cache_types_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  input  logic                  icache_read,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  arb_state_e            state;
  requester_e            winner;
  requester_e            last_grant;
  logic                  req_read;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [LINE_WIDTH-1:0] req_wdata;
  logic                  i_pend;
  logic                  d_pend;

  assign i_pend = icache_read;
  assign d_pend = dcache_read | dcache_write;

  arb_grant_sel u_grant_sel (
    .i_pend     (i_pend),
    .d_pend     (d_pend),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_read    <= 1'b0;
      req_write   <= 1'b0;
      req_address <= '0;
      req_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner == REQ_D && d_pend) begin
            state       <= SERVE_D;
            // A write-back beats a simultaneous fill so the strobes stay exclusive.
            req_write   <= dcache_write;
            req_read    <= dcache_read & ~dcache_write;
            req_address <= dcache_address & ~OFS_MASK;
            req_wdata   <= dcache_wdata;
          end else if (i_pend) begin
            state       <= SERVE_I;
            req_write   <= 1'b0;
            req_read    <= 1'b1;
            req_address <= icache_address & ~OFS_MASK;
            req_wdata   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state     <= IDLE;
            req_read  <= 1'b0;
            req_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= REQ_I;
    else if (state == IDLE && (i_pend || d_pend))
      last_grant <= winner;
  end
`else
  // Pretending I was always granted last makes every tie go to D.
  assign last_grant = REQ_I;
`endif

  assign pmem_read    = req_read;
  assign pmem_write   = req_write;
  assign pmem_address = req_address;
  assign pmem_wdata   = req_wdata;

  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;
  assign icache_resp  = ~rst & pmem_resp & (state == SERVE_I);
  assign dcache_resp  = ~rst & pmem_resp & (state == SERVE_D);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] icache_address;
  logic          icache_read;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic [AW-1:0] dcache_address;
  logic          dcache_read;
  logic          dcache_write;
  logic [LW-1:0] dcache_wdata;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic [AW-1:0] pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int compare_count  = 0;
  int mismatch_count = 0;

  logic [LW-1:0] fill_data;
  logic [AW-1:0] exp_addr;
  logic          exp_d;
  bit            rr_build;

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .icache_address (icache_address),
    .icache_read    (icache_read),
    .icache_rdata   (icache_rdata),
    .icache_resp    (icache_resp),
    .dcache_address (dcache_address),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .pmem_address   (pmem_address),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the request/response strobes just after an edge and lets outputs settle.
  task automatic applyStimulus(input logic ir, input logic dr, input logic dw, input logic resp);
    icache_read  = ir;
    dcache_read  = dr;
    dcache_write = dw;
    pmem_resp    = resp;
    #1;
  endtask

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    rr_build = 1'b1;
`else
    rr_build = 1'b0;
`endif
    rst = 1'b1;
    icache_address = '0;
    dcache_address = '0;
    dcache_wdata   = '0;
    pmem_rdata     = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_pmem_read", pmem_read, 0);
    checkOutput("rst_pmem_write", pmem_write, 0);
    checkOutput("rst_pmem_address", pmem_address, 0);
    checkOutput("rst_pmem_wdata", pmem_wdata, 0);
    checkOutput("rst_icache_resp", icache_resp, 0);
    checkOutput("rst_dcache_resp", dcache_resp, 0);

    // I-cache fill, memory answers in the third strobe cycle
    tick();
    rst = 1'b0;
    icache_address = 32'h0000_1234;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("i_idle_read", pmem_read, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("i_wait_read", pmem_read, 1);
      checkOutput("i_wait_addr", pmem_address, 32'h0000_1220);
      checkOutput("i_wait_iresp", icache_resp, 0);
    end
    tick();
    fill_data = {32{8'hA5}};
    pmem_rdata = fill_data;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("i_resp_read", pmem_read, 1);
    checkOutput("i_resp_iresp", icache_resp, 1);
    checkOutput("i_resp_rdata", icache_rdata, fill_data);
    checkOutput("i_resp_dresp", dcache_resp, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("i_done_read", pmem_read, 0);
    checkOutput("i_done_iresp", icache_resp, 0);

    // D-cache write-back against zero-wait memory
    tick();
    dcache_address = 32'h8000_0040;
    dcache_wdata   = 256'h8;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("d_idle_write", pmem_write, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("d_wb_write", pmem_write, 1);
    checkOutput("d_wb_read", pmem_read, 0);
    checkOutput("d_wb_wdata", pmem_wdata, 256'h8);
    checkOutput("d_wb_addr", pmem_address, 32'h8000_0040);
    checkOutput("d_wb_dresp", dcache_resp, 1);
    checkOutput("d_wb_iresp", icache_resp, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("d_done_write", pmem_write, 0);

    // Fresh reset so the round-robin pointer starts at I, then tie/starvation run
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    icache_address = 32'h0000_0100;
    dcache_address = 32'h0000_0200;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      exp_d    = rr_build ? ((k % 2) == 0) : 1'b1;
      exp_addr = exp_d ? 32'h0000_0200 : 32'h0000_0100;
      checkOutput($sformatf("tie%0d_addr", k), pmem_address, exp_addr);
      checkOutput($sformatf("tie%0d_dresp", k), dcache_resp, exp_d);
      checkOutput($sformatf("tie%0d_iresp", k), icache_resp, !exp_d);
      tick();
      applyStimulus(1'b1, (k == 3) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("tie%0d_idle", k), pmem_read, 0);
    end
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("tie_last_addr", pmem_address, 32'h0000_0100);
    checkOutput("tie_last_iresp", icache_resp, 1);
    checkOutput("tie_last_dresp", dcache_resp, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // D-cache drops its read one cycle after grant; transaction still completes
    tick();
    dcache_address = 32'h0000_0ABC;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    dcache_address = 32'hFFFF_FFE0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_c1_read", pmem_read, 1);
    checkOutput("drop_c1_addr", pmem_address, 32'h0000_0AA0);
    for (int c = 2; c < 4; c++) begin
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("drop_c%0d_read", c), pmem_read, 1);
    end
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("drop_c4_read", pmem_read, 1);
    checkOutput("drop_c4_addr", pmem_address, 32'h0000_0AA0);
    checkOutput("drop_c4_dresp", dcache_resp, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("drop_done_read", pmem_read, 0);

    // Reset during SERVE_I with a colliding pmem_resp
    tick();
    icache_address = 32'h0000_4000;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rsti_serve_read", pmem_read, 1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rsti_resp_blocked", icache_resp, 0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rsti_after_read", pmem_read, 0);
    checkOutput("rsti_after_write", pmem_write, 0);
    checkOutput("rsti_after_addr", pmem_address, 0);
    checkOutput("rsti_after_wdata", pmem_wdata, 0);
    checkOutput("rsti_after_iresp", icache_resp, 0);
    checkOutput("rsti_after_dresp", dcache_resp, 0);
    icache_address = 32'h0000_4010;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rsti_retry_read", pmem_read, 1);
    checkOutput("rsti_retry_addr", pmem_address, 32'h0000_4000);
    checkOutput("rsti_retry_iresp", icache_resp, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rsti_retry_done", pmem_read, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
